// File: rtl/envelope_pkg.sv
// Shared types and helpers for the vocoder envelope follower bank.
// Optional feature macro used by the bank: ENV_PEAK_HOLD_EN (per-channel peak hold).
package envelope_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } env_state_t;

  // Envelope state keeps the rectified magnitude (DATA_W-1 bits) plus fractional guard bits.
  function automatic int env_width(input int data_w, input int guard_w);
    return data_w - 1 + guard_w;
  endfunction

  // Magnitude of a sign-extended DATA_W sample; the most negative code saturates to max positive.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int data_w);
    logic signed [31:0] most_neg;
    logic [31:0]        result;
    most_neg = -(32'sd1 <<< (data_w - 1));
    if (x == most_neg) begin
      result = (32'd1 << (data_w - 1)) - 32'd1;
    end else if (x < 0) begin
      result = 32'(-x);
    end else begin
      result = 32'(x);
    end
    return result;
  endfunction

endpackage

// File: rtl/env_one_pole.sv
// Combinational one-pole update for a single channel: rectify, choose attack/release
// coefficient, move the envelope a fraction k of the way toward the target, clamp.
module env_one_pole
  import envelope_pkg::*;
#(
  parameter  int DATA_W  = 16,
  parameter  int COEF_W  = 16,
  parameter  int GUARD_W = 4,
  localparam int ENV_W   = DATA_W - 1 + GUARD_W
) (
  input  logic signed [DATA_W-1:0] x,
  input  logic        [ENV_W-1:0]  env,
  input  logic        [COEF_W-1:0] attack_k,
  input  logic        [COEF_W-1:0] release_k,
  output logic        [ENV_W-1:0]  env_next,
  output logic                     use_attack
);

  localparam int PROD_W = ENV_W + COEF_W + 2;

  logic        [ENV_W-1:0]  tgt;
  logic        [COEF_W-1:0] k;
  logic signed [ENV_W:0]    diff;
  logic signed [PROD_W-1:0] prod;
  logic signed [ENV_W+1:0]  delta;
  logic signed [ENV_W+1:0]  sum;

  // The product is floored by the arithmetic shift, so a falling envelope never undershoots the target.
  always_comb begin
    tgt        = ENV_W'(sat_abs(32'(x), DATA_W) << GUARD_W);
    use_attack = (tgt > env);
    k          = use_attack ? attack_k : release_k;
    diff       = $signed({1'b0, tgt}) - $signed({1'b0, env});
    prod       = PROD_W'(diff) * PROD_W'($signed({1'b0, k}));
    delta      = (ENV_W + 2)'(prod >>> COEF_W);
    sum        = $signed({2'b00, env}) + delta;
    if (sum < 0) begin
      env_next = '0;
    end else if (sum > $signed({2'b00, {ENV_W{1'b1}}})) begin
      env_next = '1;
    end else begin
      env_next = sum[ENV_W-1:0];
    end
  end

endmodule

// File: rtl/envelope_follower_bank.sv
// Time-multiplexed envelope follower: one shared one-pole datapath sweeps NUM_CH channels per frame.
// Define ENV_PEAK_HOLD_EN to add per-channel peak-hold counters (hold_len frames before release).
module envelope_follower_bank
  import envelope_pkg::*;
#(
  parameter int NUM_CH  = 15,
  parameter int DATA_W  = 16,
  parameter int COEF_W  = 16,
  parameter int GUARD_W = 4,
  parameter int HOLD_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pcm_valid,
  input  logic signed [DATA_W-1:0] d_in [NUM_CH],
  input  logic        [COEF_W-1:0] attack_k,
  input  logic        [COEF_W-1:0] release_k,
  input  logic        [HOLD_W-1:0] hold_len,
  input  logic                     overrun_clr,
  output logic signed [DATA_W-1:0] d_out [NUM_CH],
  output logic                     valid_out,
  output logic                     busy,
  output logic                     overrun
);

  localparam int              ENV_W   = env_width(DATA_W, GUARD_W);
  localparam int              CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  env_state_t                 state_q, state_d;
  logic        [CH_W-1:0]     ch_q, ch_d;
  logic signed [DATA_W-1:0]   samp_q [NUM_CH];
  logic signed [DATA_W-1:0]   samp_d [NUM_CH];
  logic        [COEF_W-1:0]   ak_q, ak_d;
  logic        [COEF_W-1:0]   rk_q, rk_d;
  logic        [ENV_W-1:0]    env_q [NUM_CH];
  logic        [ENV_W-1:0]    env_d [NUM_CH];
  logic signed [DATA_W-1:0]   dout_q [NUM_CH];
  logic signed [DATA_W-1:0]   dout_d [NUM_CH];
  logic                       valid_q, valid_d;
  logic                       overrun_q, overrun_d;

  logic        [ENV_W-1:0]    env_next;
  logic                       use_attack;

`ifdef ENV_PEAK_HOLD_EN
  logic        [HOLD_W-1:0]   hl_q, hl_d;
  logic        [HOLD_W-1:0]   hold_q [NUM_CH];
  logic        [HOLD_W-1:0]   hold_d [NUM_CH];
`else
  logic                       hold_unused;
  assign hold_unused = ^{hold_len, use_attack};
`endif

  env_one_pole #(
    .DATA_W  (DATA_W),
    .COEF_W  (COEF_W),
    .GUARD_W (GUARD_W)
  ) u_one_pole (
    .x          (samp_q[ch_q]),
    .env        (env_q[ch_q]),
    .attack_k   (ak_q),
    .release_k  (rk_q),
    .env_next   (env_next),
    .use_attack (use_attack)
  );

  // Sequencing, per-channel state update and frame publication.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    samp_d    = samp_q;
    ak_d      = ak_q;
    rk_d      = rk_q;
    env_d     = env_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;
`ifdef ENV_PEAK_HOLD_EN
    hl_d      = hl_q;
    hold_d    = hold_q;
`endif

    if (overrun_clr) begin
      overrun_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (pcm_valid) begin
          samp_d  = d_in;
          ak_d    = attack_k;
          rk_d    = release_k;
`ifdef ENV_PEAK_HOLD_EN
          hl_d    = hold_len;
`endif
          ch_d    = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        if (pcm_valid) begin
          overrun_d = 1'b1;
        end
`ifdef ENV_PEAK_HOLD_EN
        if (use_attack) begin
          env_d[ch_q]  = env_next;
          hold_d[ch_q] = hl_q;
        end else if (hold_q[ch_q] != '0) begin
          hold_d[ch_q] = hold_q[ch_q] - HOLD_W'(1);
        end else begin
          env_d[ch_q]  = env_next;
        end
`else
        env_d[ch_q] = env_next;
`endif
        // Outputs load on the way into DONE so d_out and valid_out appear in the same cycle.
        if (ch_q == LAST_CH) begin
          state_d = DONE;
          valid_d = 1'b1;
          for (int i = 0; i < NUM_CH; i++) begin
            dout_d[i] = {1'b0, env_d[i][ENV_W-1:GUARD_W]};
          end
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end

      DONE: begin
        if (pcm_valid) begin
          overrun_d = 1'b1;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      ak_q      <= '0;
      rk_q      <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        samp_q[i] <= '0;
        env_q[i]  <= '0;
        dout_q[i] <= '0;
      end
`ifdef ENV_PEAK_HOLD_EN
      hl_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        hold_q[i] <= '0;
      end
`endif
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      samp_q    <= samp_d;
      ak_q      <= ak_d;
      rk_q      <= rk_d;
      env_q     <= env_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef ENV_PEAK_HOLD_EN
      hl_q      <= hl_d;
      hold_q    <= hold_d;
`endif
    end
  end

  assign d_out     = dout_q;
  assign valid_out = valid_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_envelope_follower_bank.sv
// Self-checking bench for envelope_follower_bank with a frame-level arithmetic reference model.
// Build with ENV_PEAK_HOLD_EN defined to also exercise the peak-hold behaviour.
module tb_envelope_follower_bank;

  localparam int NUM_CH  = 15;
  localparam int LATENCY = NUM_CH + 1;
  localparam longint ENV_MAX = (64'd1 << 19) - 1;

  logic                clk;
  logic                rst_n;
  logic                pcm_valid;
  logic signed [15:0]  d_in [NUM_CH];
  logic        [15:0]  attack_k;
  logic        [15:0]  release_k;
  logic        [7:0]   hold_len;
  logic                overrun_clr;
  logic signed [15:0]  d_out [NUM_CH];
  logic                valid_out;
  logic                busy;
  logic                overrun;

  int     n_checks;
  int     n_fail;
  int     vcount;
  int     stim   [NUM_CH];
  longint m_env  [NUM_CH];
  int     m_hold [NUM_CH];

  envelope_follower_bank dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pcm_valid   (pcm_valid),
    .d_in        (d_in),
    .attack_k    (attack_k),
    .release_k   (release_k),
    .hold_len    (hold_len),
    .overrun_clr (overrun_clr),
    .d_out       (d_out),
    .valid_out   (valid_out),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid_out === 1'b1) vcount++;
  end

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_env[i]  = 0;
      m_hold[i] = 0;
    end
  endfunction

  // Envelope moves k/65536 of the distance to 16*|x|, rounded toward minus infinity.
  function automatic void model_frame(input int ak, input int rk, input int hl);
    longint rect, tgt, p, delta;
    bit     attack;
    for (int i = 0; i < NUM_CH; i++) begin
      rect   = (stim[i] < 0) ? -longint'(stim[i]) : longint'(stim[i]);
      if (rect > 32767) rect = 32767;
      tgt    = rect * 16;
      attack = tgt > m_env[i];
      if (attack) m_hold[i] = hl;
`ifdef ENV_PEAK_HOLD_EN
      if (!attack && m_hold[i] > 0) begin
        m_hold[i]--;
        continue;
      end
`endif
      p     = (tgt - m_env[i]) * longint'(attack ? ak : rk);
      delta = (p >= 0) ? p / 65536 : -((-p + 65535) / 65536);
      m_env[i] = m_env[i] + delta;
      if (m_env[i] < 0) m_env[i] = 0;
      if (m_env[i] > ENV_MAX) m_env[i] = ENV_MAX;
    end
  endfunction

  function automatic int model_out(input int ch);
    return int'(m_env[ch] / 16);
  endfunction

  task automatic scramble();
    for (int i = 0; i < NUM_CH; i++) d_in[i] = 16'($urandom);
    attack_k  = 16'($urandom);
    release_k = 16'($urandom);
    hold_len  = 8'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic drive_frame(input int ak, input int rk, input int hl);
    for (int i = 0; i < NUM_CH; i++) d_in[i] = 16'(stim[i]);
    attack_k  = 16'(ak);
    release_k = 16'(rk);
    hold_len  = 8'(hl);
    pcm_valid = 1'b1;
  endtask

  // Drives one frame and reports the cycle in which valid_out appeared (0 = never within budget).
  task automatic send_frame(input int ak, input int rk, input int hl, output int lat);
    @(negedge clk);
    drive_frame(ak, rk, hl);
    @(negedge clk);
    pcm_valid = 1'b0;
    scramble();
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      if (valid_out === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (valid_out !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: valid=%b busy=%b overrun=%b expected 0 0 0", valid_out, busy, overrun);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      n_checks++;
      if (d_out[i] !== 16'sd0) begin
        n_fail++;
        $display("[TB] FAIL reset_dout[%0d]: got %0d expected 0", i, d_out[i]);
      end
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_attack_step();
    int lat;
    int want [3] = '{8192, 12288, 14336};
    do_reset();
    for (int i = 0; i < NUM_CH; i++) stim[i] = 0;
    stim[0] = 16384;
    for (int f = 0; f < 3; f++) begin
      send_frame(32768, 0, 0, lat);
      model_frame(32768, 0, 0);
      n_checks++;
      if (lat !== LATENCY) begin
        n_fail++;
        $display("[TB] FAIL attack_latency f%0d: got %0d expected %0d", f, lat, LATENCY);
      end
      n_checks++;
      if (d_out[0] !== 16'(want[f]) || model_out(0) != want[f]) begin
        n_fail++;
        $display("[TB] FAIL attack_ch0 f%0d: got %0d model %0d expected %0d", f, d_out[0], model_out(0), want[f]);
      end
      for (int i = 1; i < NUM_CH; i++) begin
        n_checks++;
        if (d_out[i] !== 16'sd0) begin
          n_fail++;
          $display("[TB] FAIL attack_other[%0d] f%0d: got %0d expected 0", i, f, d_out[i]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int lat;
    do_reset();
    for (int i = 0; i < NUM_CH; i++) stim[i] = 0;
    stim[3] = -32768;
    send_frame(32768, 0, 0, lat);
    model_frame(32768, 0, 0);
    n_checks++;
    if (d_out[3] !== 16'sd16383 || model_out(3) != 16383) begin
      n_fail++;
      $display("[TB] FAIL saturation_ch3: got %0d model %0d expected 16383", d_out[3], model_out(3));
    end
  endtask

  task automatic test_release();
    int lat;
    do_reset();
    for (int i = 0; i < NUM_CH; i++) stim[i] = 0;
    stim[0] = 16384;
    send_frame(32768, 16384, 0, lat);
    model_frame(32768, 16384, 0);
    stim[0] = 0;
    send_frame(32768, 16384, 0, lat);
    model_frame(32768, 16384, 0);
    n_checks++;
    if (d_out[0] !== 16'sd6144 || model_out(0) != 6144) begin
      n_fail++;
      $display("[TB] FAIL release_ch0: got %0d model %0d expected 6144", d_out[0], model_out(0));
    end
  endtask

  task automatic test_overrun();
    int lat;
    int v0;
    do_reset();
    for (int i = 0; i < NUM_CH; i++) stim[i] = int'($signed(16'($urandom)));
    v0 = vcount;
    @(negedge clk);
    drive_frame(32768, 16384, 0);
    @(negedge clk);
    pcm_valid = 1'b0;
    scramble();
    @(negedge clk);
    @(negedge clk);
    pcm_valid = 1'b1;
    @(negedge clk);
    pcm_valid = 1'b0;
    n_checks++;
    if (overrun !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL overrun_set: overrun=%b busy=%b expected 1 1", overrun, busy);
    end
    lat = 0;
    for (int c = 4; c <= 40; c++) begin
      if (valid_out === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    model_frame(32768, 16384, 0);
    n_checks++;
    if (lat !== LATENCY) begin
      n_fail++;
      $display("[TB] FAIL overrun_latency: got %0d expected %0d", lat, LATENCY);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      n_checks++;
      if (d_out[i] !== 16'(model_out(i))) begin
        n_fail++;
        $display("[TB] FAIL overrun_dout[%0d]: got %0d expected %0d", i, d_out[i], model_out(i));
      end
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (vcount - v0 !== 1 || overrun !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL overrun_pulses: got %0d pulses overrun=%b expected 1 pulse overrun=1", vcount - v0, overrun);
    end
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL overrun_clear: got %b expected 0", overrun);
    end
    // Clear and a fresh overrun in the same cycle: the overrun must survive.
    @(negedge clk);
    drive_frame(16384, 16384, 0);
    @(negedge clk);
    pcm_valid = 1'b0;
    @(negedge clk);
    pcm_valid   = 1'b1;
    overrun_clr = 1'b1;
    @(negedge clk);
    pcm_valid   = 1'b0;
    overrun_clr = 1'b0;
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL overrun_set_wins: got %b expected 1", overrun);
    end
    repeat (20) @(negedge clk);
    model_frame(16384, 16384, 0);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
  endtask

  task automatic test_abort();
    int lat;
    int v0;
    do_reset();
    for (int i = 0; i < NUM_CH; i++) stim[i] = 20000 - i * 1000;
    send_frame(32768, 16384, 1, lat);
    model_frame(32768, 16384, 1);
    @(negedge clk);
    drive_frame(32768, 16384, 1);
    @(negedge clk);
    pcm_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || valid_out !== 1'b0 || d_out[0] !== 16'sd0) begin
      n_fail++;
      $display("[TB] FAIL abort_clear: busy=%b valid=%b d_out0=%0d expected 0 0 0", busy, valid_out, d_out[0]);
    end
    v0 = vcount;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (25) @(negedge clk);
    n_checks++;
    if (vcount !== v0) begin
      n_fail++;
      $display("[TB] FAIL abort_no_valid: got %0d pulses expected 0", vcount - v0);
    end
    send_frame(32768, 16384, 0, lat);
    model_frame(32768, 16384, 0);
    for (int i = 0; i < NUM_CH; i++) begin
      n_checks++;
      if (d_out[i] !== 16'(model_out(i))) begin
        n_fail++;
        $display("[TB] FAIL abort_after[%0d]: got %0d expected %0d", i, d_out[i], model_out(i));
      end
    end
  endtask

  task automatic test_random();
    int lat, ak, rk, hl, sel;
    do_reset();
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sel = $urandom_range(0, 5);
        case (sel)
          0:       stim[i] = -32768;
          1:       stim[i] = 32767;
          2:       stim[i] = 0;
          default: stim[i] = int'($signed(16'($urandom)));
        endcase
      end
      ak = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 65535);
      rk = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 65535);
      hl = $urandom_range(0, 3);
      send_frame(ak, rk, hl, lat);
      model_frame(ak, rk, hl);
      n_checks++;
      if (lat !== LATENCY) begin
        n_fail++;
        $display("[TB] FAIL random_latency f%0d: got %0d expected %0d", f, lat, LATENCY);
      end
      for (int i = 0; i < NUM_CH; i++) begin
        n_checks++;
        if (d_out[i] !== 16'(model_out(i))) begin
          n_fail++;
          $display("[TB] FAIL random_dout f%0d[%0d]: got %0d expected %0d", f, i, d_out[i], model_out(i));
        end
      end
    end
  endtask

`ifdef ENV_PEAK_HOLD_EN
  task automatic test_peak_hold();
    int lat;
    int want [3] = '{8192, 8192, 6144};
    do_reset();
    for (int i = 0; i < NUM_CH; i++) stim[i] = 0;
    stim[0] = 16384;
    send_frame(32768, 16384, 2, lat);
    model_frame(32768, 16384, 2);
    stim[0] = 0;
    for (int f = 0; f < 3; f++) begin
      send_frame(32768, 16384, 2, lat);
      model_frame(32768, 16384, 2);
      n_checks++;
      if (d_out[0] !== 16'(want[f]) || model_out(0) != want[f]) begin
        n_fail++;
        $display("[TB] FAIL hold_ch0 f%0d: got %0d model %0d expected %0d", f, d_out[0], model_out(0), want[f]);
      end
    end
  endtask
`endif

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    vcount      = 0;
    pcm_valid   = 1'b0;
    overrun_clr = 1'b0;
    attack_k    = '0;
    release_k   = '0;
    hold_len    = '0;
    for (int i = 0; i < NUM_CH; i++) d_in[i] = '0;
    test_reset();
    test_attack_step();
    test_saturation();
    test_release();
    test_overrun();
    test_abort();
    test_random();
`ifdef ENV_PEAK_HOLD_EN
    test_peak_hold();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
